// File: rtl/toy_bus_ack_rr_arb_node.sv
// toy_bus_ack_rr_arb_node: 2-to-1 round-robin merge node for the ToyBusAck channel, registered output.
// Define TOY_BUS_ACK_ARB_STAT_EN to add grant and stall statistics counters.
module toy_bus_ack_rr_arb_node #(
    parameter int DATA_W = 256,
    parameter int SB_W   = 10,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic              in0_opcode,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [SB_W-1:0]   in0_sideband,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,

    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic              in1_opcode,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [SB_W-1:0]   in1_sideband,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,

    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic              out0_opcode,
    output logic [DATA_W-1:0] out0_data,
    output logic [SB_W-1:0]   out0_sideband,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id
`ifdef TOY_BUS_ACK_ARB_STAT_EN
    ,
    output logic [15:0]       stat_grant0_cnt,
    output logic [15:0]       stat_grant1_cnt,
    output logic [15:0]       stat_stall_cnt
`endif
);

    typedef struct packed {
        logic              opcode;
        logic [DATA_W-1:0] data;
        logic [SB_W-1:0]   sideband;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
    } beat_t;

    beat_t in0_beat;
    beat_t in1_beat;
    beat_t win_beat;
    beat_t out_q;

    logic rr_ptr;
    logic load_en;
    logic grant0;
    logic grant1;
    logic accept;

    assign in0_beat = '{in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};
    assign in1_beat = '{in1_opcode, in1_data, in1_sideband, in1_src_id, in1_tgt_id};

    // The output slot can take a new beat when empty or when it drains this cycle.
    assign load_en = !out0_vld || out0_rdy;

    // A lone valid port always wins; on contention rr_ptr picks the port.
    assign grant0 = in0_vld && (!in1_vld || !rr_ptr);
    assign grant1 = in1_vld && (!in0_vld ||  rr_ptr);

    assign in0_rdy  = !rst && load_en && grant0;
    assign in1_rdy  = !rst && load_en && grant1;
    assign accept   = in0_rdy || in1_rdy;
    assign win_beat = grant1 ? in1_beat : in0_beat;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out0_vld <= 1'b0;
            // NOTE: the payload register is reset because the consumer may observe it after reset.
            out_q    <= '0;
            rr_ptr   <= 1'b0;
        end else if (load_en) begin
            out0_vld <= accept;
            if (accept) begin
                out_q  <= win_beat;
                // The winner drops to lowest priority: port 0 winning points at port 1.
                rr_ptr <= grant0;
            end
        end
    end

    assign out0_opcode   = out_q.opcode;
    assign out0_data     = out_q.data;
    assign out0_sideband = out_q.sideband;
    assign out0_src_id   = out_q.src_id;
    assign out0_tgt_id   = out_q.tgt_id;

`ifdef TOY_BUS_ACK_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0_cnt <= 16'h0000;
            stat_grant1_cnt <= 16'h0000;
            stat_stall_cnt  <= 16'h0000;
        end else begin
            if (in0_rdy) stat_grant0_cnt <= stat_grant0_cnt + 16'h0001;
            if (in1_rdy) stat_grant1_cnt <= stat_grant1_cnt + 16'h0001;
            // Stall counter saturates; grant counters wrap.
            if (out0_vld && !out0_rdy && stat_stall_cnt != 16'hFFFF)
                stat_stall_cnt <= stat_stall_cnt + 16'h0001;
        end
    end
`endif

    // Upstream must hold its payload while a beat waits to be accepted.
    a_in0_hold: assert property (@(posedge clk) disable iff (rst)
        in0_vld && !in0_rdy |=> !in0_vld || $stable(in0_beat));
    a_in1_hold: assert property (@(posedge clk) disable iff (rst)
        in1_vld && !in1_rdy |=> !in1_vld || $stable(in1_beat));
    a_one_rdy: assert property (@(posedge clk) !(in0_rdy && in1_rdy));

endmodule

// File: tb/tb_toy_bus_ack_rr_arb_node.sv
// tb_toy_bus_ack_rr_arb_node: table-driven cycle vectors plus a payload scoreboard for the ack merge node.
// Define TOY_BUS_ACK_ARB_STAT_EN to also check the statistics counters.
module tb_toy_bus_ack_rr_arb_node;

    localparam int DATA_W = 256;
    localparam int SB_W   = 10;
    localparam int ID_W   = 4;

    typedef struct packed {
        logic              opcode;
        logic [DATA_W-1:0] data;
        logic [SB_W-1:0]   sideband;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
    } beat_t;

    // One clock cycle: inputs to drive and the rdy/vld values expected before the edge.
    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] t0;
        logic [3:0] g0;
        logic       v1;
        logic [7:0] t1;
        logic [3:0] g1;
        logic       ordy;
        logic       er0;
        logic       er1;
        logic       eov;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic in0_vld, in0_rdy, in1_vld, in1_rdy;
    logic out0_vld, out0_rdy;
    beat_t b0, b1, out_beat;
    logic              out0_opcode;
    logic [DATA_W-1:0] out0_data;
    logic [SB_W-1:0]   out0_sideband;
    logic [ID_W-1:0]   out0_src_id;
    logic [ID_W-1:0]   out0_tgt_id;
`ifdef TOY_BUS_ACK_ARB_STAT_EN
    logic [15:0] stat_grant0_cnt, stat_grant1_cnt, stat_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    beat_t sb[$];
    vec_t  vecs[$];

    always #5 clk = ~clk;

    assign out_beat = '{out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id};

    toy_bus_ack_rr_arb_node #(.DATA_W(DATA_W), .SB_W(SB_W), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in0_vld       (in0_vld),
        .in0_rdy       (in0_rdy),
        .in0_opcode    (b0.opcode),
        .in0_data      (b0.data),
        .in0_sideband  (b0.sideband),
        .in0_src_id    (b0.src_id),
        .in0_tgt_id    (b0.tgt_id),
        .in1_vld       (in1_vld),
        .in1_rdy       (in1_rdy),
        .in1_opcode    (b1.opcode),
        .in1_data      (b1.data),
        .in1_sideband  (b1.sideband),
        .in1_src_id    (b1.src_id),
        .in1_tgt_id    (b1.tgt_id),
        .out0_vld      (out0_vld),
        .out0_rdy      (out0_rdy),
        .out0_opcode   (out0_opcode),
        .out0_data     (out0_data),
        .out0_sideband (out0_sideband),
        .out0_src_id   (out0_src_id),
        .out0_tgt_id   (out0_tgt_id)
`ifdef TOY_BUS_ACK_ARB_STAT_EN
        ,
        .stat_grant0_cnt (stat_grant0_cnt),
        .stat_grant1_cnt (stat_grant1_cnt),
        .stat_stall_cnt  (stat_stall_cnt)
`endif
    );

    function automatic beat_t mk_beat(input logic port, input logic [7:0] tag, input logic [3:0] tgt);
        beat_t b;
        b.opcode   = tag[0];
        b.data     = DATA_W'({port, tag});
        b.sideband = SB_W'({port, tag});
        b.src_id   = port ? 4'hB : 4'h3;
        b.tgt_id   = tgt;
        return b;
    endfunction

    function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] t0, input logic [3:0] g0,
                                input logic v1, input logic [7:0] t1, input logic [3:0] g1,
                                input logic ordy, input logic er0, input logic er1, input logic eov);
        vec_t v;
        v = '{r, v0, t0, g0, v1, t1, g1, ordy, er0, er1, eov};
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive, compare before the next edge, then advance one cycle.
    task automatic apply(input vec_t v, input int idx);
        rst      = v.rst;
        in0_vld  = v.v0;
        in1_vld  = v.v1;
        b0       = mk_beat(1'b0, v.t0, v.g0);
        b1       = mk_beat(1'b1, v.t1, v.g1);
        out0_rdy = v.ordy;
        #3;
        check($sformatf("row%0d in0_rdy", idx), in0_rdy, v.er0);
        check($sformatf("row%0d in1_rdy", idx), in1_rdy, v.er1);
        check($sformatf("row%0d out0_vld", idx), out0_vld, v.eov);
        if (out0_vld) begin
            if (sb.size() == 0) begin
                check($sformatf("row%0d unexpected out0_vld", idx), out0_vld, 1'b0);
            end else begin
                check($sformatf("row%0d out0 payload", idx), out_beat, sb[0]);
                if (out0_rdy) void'(sb.pop_front());
            end
        end
        if (v.rst) sb.delete();
        else begin
            if (v.er0) sb.push_back(mk_beat(1'b0, v.t0, v.g0));
            if (v.er1) sb.push_back(mk_beat(1'b1, v.t1, v.g1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in0_vld  = 1'b1;
        in1_vld  = 1'b1;
        b0       = mk_beat(1'b0, 8'hEE, 4'h1);
        b1       = mk_beat(1'b1, 8'hDD, 4'h2);
        out0_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check("reset in0_rdy", in0_rdy, 1'b0);
        check("reset in1_rdy", in1_rdy, 1'b0);
        check("reset out0_vld", out0_vld, 1'b0);
        check("reset out0 payload", out_beat, '0);
        @(posedge clk);
        #1;

        // Single in0 beat, 1-cycle latency, then idle.
        vecs.push_back(mk(0, 1, 8'hA5, 4'h2, 0, 8'h00, 4'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 0));
        // Both ports streaming: strict alternation, no bubbles.
        vecs.push_back(mk(1, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h10, 4'h1, 1, 8'h20, 4'h1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 4'h1, 1, 8'h20, 4'h1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h11, 4'h1, 1, 8'h21, 4'h1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h12, 4'h1, 1, 8'h21, 4'h1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h12, 4'h1, 1, 8'h22, 4'h1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h13, 4'h1, 1, 8'h22, 4'h1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 1));
        // Backpressure holding an in1 beat; in0 wins on release.
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1, 8'h30, 4'h3, 1, 0, 1, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 8'h40, 4'h4, 1, 8'h31, 4'h3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h40, 4'h4, 1, 8'h31, 4'h3, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1, 8'h31, 4'h3, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 1));
        // in1-only stream with out0_rdy toggling.
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1, 8'h50, 4'h5, 1, 0, 1, 0));
        for (int k = 1; k < 5; k++) begin
            vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1, 8'h50 + 8'(k), 4'h5, 0, 0, 0, 1));
            vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1, 8'h50 + 8'(k), 4'h5, 1, 0, 1, 1));
        end
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 0));
        // Reset while a beat is pending and in1 waits; in0 wins first afterwards.
        vecs.push_back(mk(0, 1, 8'h60, 4'h6, 0, 8'h00, 4'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1, 8'h70, 4'h7, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1, 8'h70, 4'h7, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1, 8'h70, 4'h7, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h61, 4'h6, 1, 8'h70, 4'h7, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1, 8'h70, 4'h7, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 0));
        // Statistics window: 3 in0 grants, 2 in1 grants, 4 stall cycles.
        vecs.push_back(mk(1, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h80, 4'h8, 1, 8'h90, 4'h9, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h81, 4'h8, 1, 8'h90, 4'h9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h81, 4'h8, 1, 8'h90, 4'h9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h81, 4'h8, 1, 8'h90, 4'h9, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h81, 4'h8, 1, 8'h91, 4'h9, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h82, 4'h8, 1, 8'h91, 4'h9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h82, 4'h8, 1, 8'h91, 4'h9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h82, 4'h8, 1, 8'h91, 4'h9, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h82, 4'h8, 0, 8'h00, 4'h0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 1));

        foreach (vecs[i]) apply(vecs[i], i);
        check("scoreboard drained", sb.size(), 0);

`ifdef TOY_BUS_ACK_ARB_STAT_EN
        check("stat_grant0_cnt", stat_grant0_cnt, 16'd3);
        check("stat_grant1_cnt", stat_grant1_cnt, 16'd2);
        check("stat_stall_cnt", stat_stall_cnt, 16'd4);
        force dut.stat_grant0_cnt = 16'hFFFF;
        #1;
        release dut.stat_grant0_cnt;
        apply(mk(0, 1, 8'hA0, 4'h0, 0, 8'h00, 4'h0, 1, 1, 0, 0), 1000);
        apply(mk(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 1), 1001);
        check("stat_grant0_cnt wrap", stat_grant0_cnt, 16'h0000);
        check("stat_grant1_cnt after wrap", stat_grant1_cnt, 16'd2);
        check("stat_stall_cnt after wrap", stat_stall_cnt, 16'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toy_bus_ack_rr_arb_node.md
Name: toy_bus_ack_rr_arb_node

Overview:
- 2-to-1 merge node for the ToyBusAck channel; the counterpart of the ack tgt_id decoder/demux.
- Collects ack beats from two upstream ports and round-robin arbitrates between them.
- Drives one registered output toward the ack consumer, at full throughput with 1-cycle latency.
- Sits at each arbitration point of the toy_bus ack network, where two decoder branches converge.

Parameters:
- DATA_W, 256, ack data width
- SB_W, 10, sideband width
- ID_W, 4, src_id/tgt_id width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in0_vld  input  1  port 0 beat valid
- in0_rdy  output  1  port 0 beat accepted
- in0_opcode  input  1  port 0 opcode
- in0_data  input  DATA_W  port 0 data
- in0_sideband  input  SB_W  port 0 sideband
- in0_src_id  input  ID_W  port 0 source id
- in0_tgt_id  input  ID_W  port 0 target id
- in1_vld/in1_rdy/in1_opcode/in1_data/in1_sideband/in1_src_id/in1_tgt_id  same as port 0, for port 1
- out0_vld  output  1  registered output valid
- out0_rdy  input  1  downstream ready
- out0_opcode/out0_data/out0_sideband/out0_src_id/out0_tgt_id  output  1/DATA_W/SB_W/ID_W/ID_W  registered payload

Behaviour:
- Clock and reset: clk is the single clock. rst is synchronous and active-high.
- Reset values: out0_vld=0, all out0 payload=0, rr_ptr=0 (port 0 has priority), in0_rdy=in1_rdy=0 while rst is high.
- Handshake:
  - Valid/ready on every port; a beat transfers on the cycle vld&&rdy.
  - vld must not depend on rdy.
  - Payload must be held stable while vld && !rdy (upstream rule; checked by assertion).
- Output stage: a single pipe register. load_en = !out0_vld || out0_rdy. No combinational path from in*_vld to out0_vld.
- Arbitration (combinational, each cycle):
  - Only one valid: that port wins.
  - Both valid: rr_ptr==0 selects port 0, rr_ptr==1 selects port 1.
- in0_rdy = load_en && grant0; in1_rdy = load_en && grant1.
  - At most one in*_rdy is high in any cycle.
  - rdy may be high for a non-valid port only if that port is granted. Grant is gated by vld, so this does not occur.
- On an accepted beat:
  - The payload of the granted port is registered into out0_* and out0_vld <= 1 next cycle.
  - rr_ptr <= ~winner. The port that just won gets lowest priority.
- rr_ptr updates only on an accepted beat. It never advances on stall or idle cycles.
- On out0_vld && out0_rdy with no new accept: out0_vld <= 0. Payload holds its last value; it is not cleared.
- Latency: accept at cycle N -> out0_vld at N+1. Throughput is 1 beat/cycle with continuous out0_rdy=1.
- Fairness: with both ports continuously valid and out0_rdy=1, grants strictly alternate. Maximum wait is 1 beat.
- Backpressure: out0_vld && !out0_rdy -> load_en=0, both in*_rdy=0, out0 payload frozen, rr_ptr frozen.
- Simultaneous drain and fill: out0_rdy=1 with a new winner -> out0 is replaced in the same cycle, with no bubble.
- Reset mid-operation: the pending out0 beat is discarded (out0_vld=0 next cycle), rr_ptr=0. Upstream beats not yet accepted remain the upstream's responsibility.
- Routing: tgt_id/src_id pass through unmodified. No routing decision is made here.

Optional Feature:
- Macro: TOY_BUS_ACK_ARB_STAT_EN.
- With the macro defined:
  - Adds outputs stat_grant0_cnt and stat_grant1_cnt, each 16 bits. Each increments on its port's accepted beat and wraps 0xFFFF->0x0000.
  - Adds output stat_stall_cnt, 16 bits. It counts cycles with out0_vld && !out0_rdy and saturates at 0xFFFF.
  - All three counters reset to 0 on rst.
- Without the macro: these ports and registers do not exist. Functional behaviour is identical.

Test Plan:
- Reset, then in0 beat: in0_vld=1, tgt_id=4'h2, data=256'hA5 at cycle 1, out0_rdy=1 -> in0_rdy=1 at cycle 1; out0_vld=1 with data A5 and tgt 2 at cycle 2; out0_vld=0 at cycle 3.
- Both ports continuously valid (in0 data=0x10.., in1 data=0x20..), out0_rdy=1 for 6 cycles -> output order is in0,in1,in0,in1,in0,in1; one beat per cycle; no bubbles.
- Backpressure:
  - out0 holds a beat from in1 while out0_rdy=0 for 4 cycles with both inputs valid -> both in*_rdy=0, out0 payload stable, rr_ptr unchanged.
  - On out0_rdy=1 -> in0 is granted that same cycle.
- Single-port streaming: in1 only, 5 beats, out0_rdy toggling 1,0,1,0,1 -> exactly 5 beats out, in order, none duplicated or dropped.
- Reset asserted while out0_vld=1 and in1_vld=1 -> next cycle out0_vld=0, in1_rdy=0. After reset release with both valid, in0 wins first.
- With TOY_BUS_ACK_ARB_STAT_EN: 3 in0 beats, 2 in1 beats, 4 stall cycles -> stat_grant0_cnt=3, stat_grant1_cnt=2, stat_stall_cnt=4. Forced stat_grant0_cnt=0xFFFF plus one in0 beat -> wraps to 0.
